// File: rtl/clint_pkg.sv
// clint_pkg
//   Shared types and constants for the core-local interruptor (CLINT).
//   - dbus_req_t / dbus_resp_t : data-bus request/response structs
//   - CLINT_*_OFF              : register offsets inside the 64 KiB window
//   - clint_state_t            : bus responder FSM states
//   - merge_bytes              : byte-lane write merge helper
package clint_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } clint_state_t;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strobe);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strobe[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// clint_mtime_counter
//   Free-running 64-bit mtime with a clock prescaler and a byte-strobed
//   software write port.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     we         : write enable (commit this cycle)
//     wstrb      : byte strobes for the write
//     wdata      : write data
//     mtime      : current counter value
module clint_mtime_counter
  import clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [7:0]  wstrb,
  input  logic [63:0] wdata,
  output logic [63:0] mtime
);

  logic [31:0] prescaler;
  logic        tick;

  assign tick = (prescaler == 32'(TICK_DIV - 1));

  // The prescaler keeps running even when a software write lands on a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 32'd1;
    end
  end

  // A software write takes priority; a coincident tick is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime <= '0;
    end else if (we) begin
      mtime <= merge_bytes(mtime, wdata, wstrb);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

endmodule

// File: rtl/clint.sv
// clint
//   Memory-mapped core-local interruptor on the data-bus responder side.
//   Provides msip (software interrupt), mtimecmp and a free-running mtime.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     dreq       : data-bus request from the core
//     dresp      : data-bus response (addr_ok/data_ok pulse for one cycle)
//     trint      : timer interrupt level (mtime >= mtimecmp)
//     swint      : software interrupt level (msip bit 0)
//     mtime_o    : current mtime
//   Build option:
//     CLINT_MTIME_WRITE_EN : when defined, software writes to mtime take
//                            effect; otherwise they are acknowledged and
//                            discarded.
module clint
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int          TICK_DIV  = 1,
  parameter int          RESP_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        trint,
  output logic        swint,
  output logic [63:0] mtime_o
);

  clint_state_t state, state_next;

  logic [31:0] wait_cnt;
  logic [15:3] req_off;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;

  logic        hit;
  logic [15:0] off;
  logic        wr_en;
  logic        mtime_we;
  logic        msip;
  logic [63:0] mtimecmp;
  logic [63:0] mtime;
  logic [63:0] rdata;

  // Byte size and sub-doubleword address bits do not affect decode.
  logic unused_bits;
  assign unused_bits = ^{dreq.size, dreq.addr[2:0]};

  assign hit   = dreq.valid && (dreq.addr[63:16] == BASE_ADDR[63:16]);
  assign off   = {req_off, 3'b000};
  assign wr_en = (state == RESP) && (|req_strobe);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Dropping valid while waiting abandons the transaction silently.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (hit) state_next = WAIT;
      WAIT: begin
        if (!dreq.valid)        state_next = IDLE;
        else if (wait_cnt == 0) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt   <= '0;
      req_off    <= '0;
      req_strobe <= '0;
      req_data   <= '0;
    end else if (state == IDLE && hit) begin
      wait_cnt   <= 32'(RESP_LAT - 1);
      req_off    <= dreq.addr[15:3];
      req_strobe <= dreq.strobe;
      req_data   <= dreq.data;
    end else if (state == WAIT && wait_cnt != 0) begin
      wait_cnt   <= wait_cnt - 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msip <= 1'b0;
    end else if (wr_en && off == CLINT_MSIP_OFF && req_strobe[0]) begin
      msip <= req_data[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtimecmp <= '1;
    end else if (wr_en && off == CLINT_MTIMECMP_OFF) begin
      mtimecmp <= merge_bytes(mtimecmp, req_data, req_strobe);
    end
  end

`ifdef CLINT_MTIME_WRITE_EN
  assign mtime_we = wr_en && (off == CLINT_MTIME_OFF);
`else
  assign mtime_we = 1'b0;
`endif

  clint_mtime_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime (
    .clk   (clk),
    .reset (reset),
    .we    (mtime_we),
    .wstrb (req_strobe),
    .wdata (req_data),
    .mtime (mtime)
  );

  always_comb begin
    rdata = '0;
    case (off)
      CLINT_MSIP_OFF:     rdata = {63'd0, msip};
      CLINT_MTIMECMP_OFF: rdata = mtimecmp;
      CLINT_MTIME_OFF:    rdata = mtime;
      default:            rdata = '0;
    endcase
  end

  // Response is decoded from state so reset clears it immediately.
  always_comb begin
    dresp = '0;
    if (state == RESP) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = rdata;
    end
  end

  assign trint   = (mtime >= mtimecmp);
  assign swint   = msip;
  assign mtime_o = mtime;

endmodule

// File: tb/tb_clint.sv
// tb_clint
//   Directed testbench for clint. Two instances: dut (RESP_LAT=1) and
//   dut3 (RESP_LAT=3), both with TICK_DIV=1, sharing clock and reset.
`timescale 1ns/1ps
module tb_clint;
  import clint_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

  logic        clk = 1'b0;
  logic        reset;
  dbus_req_t   dreq, dreq3;
  dbus_resp_t  dresp, dresp3;
  logic        trint, swint, trint3, swint3;
  logic [63:0] mtime_o, mtime3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clint #(.BASE_ADDR(BASE), .TICK_DIV(1), .RESP_LAT(1)) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp),
    .trint(trint), .swint(swint), .mtime_o(mtime_o)
  );

  clint #(.BASE_ADDR(BASE), .TICK_DIV(1), .RESP_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .dreq(dreq3), .dresp(dresp3),
    .trint(trint3), .swint(swint3), .mtime_o(mtime3)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Call at a negedge; returns at the negedge inside the RESP cycle with
  // valid already dropped. lat counts negedges from request to data_ok.
  task automatic applyStimulus(input int which, input logic [63:0] addr,
                               input logic [7:0] strobe, input logic [63:0] wdata,
                               output logic [63:0] rdata, output int lat);
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = addr;
    r.size   = 3'd3;
    r.strobe = strobe;
    r.data   = wdata;
    if (which == 3) dreq3 = r; else dreq = r;
    lat   = 0;
    rdata = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (which == 3) begin
        if (dresp3.data_ok) begin lat = i; rdata = dresp3.data; break; end
      end else begin
        if (dresp.data_ok) begin lat = i; rdata = dresp.data; break; end
      end
    end
    dreq  = '0;
    dreq3 = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    dreq  = '0;
    dreq3 = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rd;
    int          lat;
    int          saw;
    dbus_req_t   r;

    reset = 1'b1;
    dreq  = '0;
    dreq3 = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    checkOutput("rst_mtime", mtime_o, 64'd0);
    checkOutput("rst_trint", 64'(trint), 64'd0);
    checkOutput("rst_swint", 64'(swint), 64'd0);
    checkOutput("rst_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    checkOutput("rst_data", dresp.data, 64'd0);
    checkOutput("rst_mtime3", mtime3, 64'd0);
    checkOutput("rst_trint3", 64'(trint3), 64'd0);
    reset = 1'b0;

    // Ten idle cycles
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (dresp.data_ok) saw++;
    end
    checkOutput("idle_mtime", mtime_o, 64'd10);
    checkOutput("idle_trint", 64'(trint), 64'd0);
    checkOutput("idle_swint", 64'(swint), 64'd0);
    checkOutput("idle_no_ok", 64'(saw), 64'd0);

    // msip set / read / clear / masked write
    applyStimulus(1, BASE, 8'h01, 64'h1, rd, lat);
    checkOutput("msip_lat", 64'(lat), 64'd2);
    checkOutput("msip_addr_ok", 64'(dresp.addr_ok), 64'd1);
    checkOutput("msip_swint_in_resp", 64'(swint), 64'd0);
    @(negedge clk);
    checkOutput("msip_swint_set", 64'(swint), 64'd1);
    checkOutput("msip_ok_gone", 64'(dresp.data_ok), 64'd0);
    applyStimulus(1, BASE, 8'h00, 64'h0, rd, lat);
    checkOutput("msip_read", rd, 64'd1);
    applyStimulus(1, BASE, 8'h01, 64'h0, rd, lat);
    @(negedge clk);
    checkOutput("msip_swint_clr", 64'(swint), 64'd0);
    applyStimulus(1, BASE, 8'hFE, 64'hFFFF_FFFF_FFFF_FFFF, rd, lat);
    @(negedge clk);
    checkOutput("msip_lane0_masked", 64'(swint), 64'd0);

    // mtimecmp = 50: trint low until mtime reaches 50, then held
    applyStimulus(1, BASE + 64'h4000, 8'hFF, 64'd50, rd, lat);
    saw = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mtime_o == 64'd50) break;
      if (trint) saw++;
    end
    checkOutput("cmp_early_trint", 64'(saw), 64'd0);
    checkOutput("cmp_reach50", mtime_o, 64'd50);
    checkOutput("cmp_trint_set", 64'(trint), 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("cmp_trint_hold", 64'(trint), 64'd1);
    applyStimulus(1, BASE + 64'h4000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd, lat);
    checkOutput("cmp_trint_in_resp", 64'(trint), 64'd1);
    @(negedge clk);
    checkOutput("cmp_trint_clr", 64'(trint), 64'd0);

    // Unmapped offsets and a miss outside the window
    applyStimulus(1, BASE + 64'h1000, 8'hFF, 64'h1234_5678_9ABC_DEF0, rd, lat);
    checkOutput("unmap_w_lat", 64'(lat), 64'd2);
    applyStimulus(1, BASE + 64'h1000, 8'h00, 64'h0, rd, lat);
    checkOutput("unmap_read", rd, 64'd0);
    applyStimulus(1, BASE + 64'h4008, 8'h00, 64'h0, rd, lat);
    checkOutput("unmap_4008_read", rd, 64'd0);
    r = '0;
    r.valid  = 1'b1;
    r.addr   = 64'h0000_0000_0300_0000;
    r.strobe = 8'h01;
    r.data   = 64'h1;
    dreq = r;
    saw = 0;
    repeat (5) begin
      @(negedge clk);
      if (dresp.data_ok) saw++;
    end
    dreq = '0;
    checkOutput("miss_no_ok", 64'(saw), 64'd0);
    @(negedge clk);
    checkOutput("miss_swint", 64'(swint), 64'd0);

    // 32-bit write to the high half of mtimecmp
    doReset();
    applyStimulus(1, BASE + 64'h4004, 8'hF0, 64'h0000_0001_0000_0000, rd, lat);
    applyStimulus(1, BASE + 64'h4000, 8'h00, 64'h0, rd, lat);
    checkOutput("cmp_hi_write", rd, 64'h0000_0001_FFFF_FFFF);

    // mtime read straight after reset release
    doReset();
    applyStimulus(1, BASE + 64'hBFF8, 8'h00, 64'h0, rd, lat);
    checkOutput("mtime_read_lat", 64'(lat), 64'd2);
    checkOutput("mtime_read", rd, 64'd2);

    // mtime write near wrap
    doReset();
    applyStimulus(1, BASE + 64'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, rd, lat);
    checkOutput("mtime_w_lat", 64'(lat), 64'd2);
    checkOutput("mtime_w_resp", mtime_o, 64'd2);
    @(negedge clk);
`ifdef CLINT_MTIME_WRITE_EN
    checkOutput("mtime_w_c1", mtime_o, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    checkOutput("mtime_w_c2", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    checkOutput("mtime_w_wrap", mtime_o, 64'd0);
`else
    checkOutput("mtime_w_c1", mtime_o, 64'd3);
    @(negedge clk);
    checkOutput("mtime_w_c2", mtime_o, 64'd4);
    @(negedge clk);
    checkOutput("mtime_w_c3", mtime_o, 64'd5);
`endif

    // RESP_LAT=3 instance: normal write latency
    doReset();
    applyStimulus(3, BASE, 8'h01, 64'h1, rd, lat);
    checkOutput("l3_lat", 64'(lat), 64'd4);
    @(negedge clk);
    checkOutput("l3_swint_set", 64'(swint3), 64'd1);
    applyStimulus(3, BASE, 8'h01, 64'h0, rd, lat);
    @(negedge clk);
    checkOutput("l3_swint_clr", 64'(swint3), 64'd0);

    // Drop valid during WAIT
    r = '0;
    r.valid  = 1'b1;
    r.addr   = BASE;
    r.strobe = 8'h01;
    r.data   = 64'h1;
    dreq3 = r;
    @(negedge clk);
    checkOutput("drop_wait_ok", 64'(dresp3.data_ok), 64'd0);
    dreq3.valid = 1'b0;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (dresp3.data_ok) saw++;
    end
    checkOutput("drop_no_ok", 64'(saw), 64'd0);
    checkOutput("drop_swint", 64'(swint3), 64'd0);
    dreq3 = '0;
    applyStimulus(3, BASE, 8'h00, 64'h0, rd, lat);
    checkOutput("drop_read_lat", 64'(lat), 64'd4);
    checkOutput("drop_read_msip", rd, 64'd0);

    // Reset asserted during WAIT
    dreq3 = r;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst_wait_ok", 64'({dresp3.addr_ok, dresp3.data_ok}), 64'd0);
    checkOutput("rst_wait_data", dresp3.data, 64'd0);
    dreq3 = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("rst_wait_swint", 64'(swint3), 64'd0);
    applyStimulus(3, BASE, 8'h00, 64'h0, rd, lat);
    checkOutput("rst_wait_idle_lat", 64'(lat), 64'd4);
    checkOutput("rst_wait_msip", rd, 64'd0);

    // Reset asserted during RESP: response cleared, write not committed
    dreq3 = r;
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dresp3.data_ok) begin saw = 1; break; end
    end
    checkOutput("rst_resp_reached", 64'(saw), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_resp_ok", 64'({dresp3.addr_ok, dresp3.data_ok}), 64'd0);
    checkOutput("rst_resp_data", dresp3.data, 64'd0);
    dreq3 = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_resp_no_commit", 64'(swint3), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
